// File: rtl/fb_window_writer_pkg.sv
// Shared geometry helpers, FSM state type and window-command payload for the framebuffer writer.
package fb_window_writer_pkg;

  localparam int unsigned DEF_PIXEL_WIDTH      = 64;
  localparam int unsigned DEF_PIXEL_HEIGHT     = 32;
  localparam int unsigned DEF_PIXEL_HALFHEIGHT = 16;
  localparam int unsigned DEF_BYTES_PER_PIXEL  = 2;
  localparam int unsigned DEF_X_BITS           = $clog2(DEF_PIXEL_WIDTH);
  localparam int unsigned DEF_Y_BITS           = $clog2(DEF_PIXEL_HEIGHT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_FILL   = 2'd3
  } state_e;

  // Latched window: left edge for row wrap, inclusive right/bottom edges for exact end detection
  typedef struct packed {
    logic [DEF_X_BITS-1:0] x0;
    logic [DEF_X_BITS-1:0] x_last;
    logic [DEF_Y_BITS-1:0] y_last;
    logic                  msb_first;
  } window_cmd_t;

  function automatic int unsigned num_colour_idx_bits(input int unsigned bpp);
    return (bpp <= 1) ? 0 : $clog2(bpp);
  endfunction

  function automatic int unsigned num_subpanelselect_bits(input int unsigned height,
                                                          input int unsigned halfheight);
    return (height / halfheight <= 1) ? 0 : $clog2(height / halfheight);
  endfunction

  function automatic int unsigned num_address_b_bits(input int unsigned width,
                                                     input int unsigned halfheight);
    return $clog2(halfheight) + $clog2(width);
  endfunction

  function automatic int unsigned num_address_a_bits(input int unsigned width,
                                                     input int unsigned height,
                                                     input int unsigned halfheight,
                                                     input int unsigned bpp);
    return num_address_b_bits(width, halfheight) + num_subpanelselect_bits(height, halfheight)
           + num_colour_idx_bits(bpp);
  endfunction

endpackage

// File: rtl/fb_window_writer_addr_pack.sv
// Maps (x, y, colour index) to the port-A address {row_in_half, column, subpanel, colour_idx}.
module fb_addr_pack
  import fb_window_writer_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH      = DEF_PIXEL_WIDTH,
  parameter int unsigned PIXEL_HEIGHT     = DEF_PIXEL_HEIGHT,
  parameter int unsigned PIXEL_HALFHEIGHT = DEF_PIXEL_HALFHEIGHT,
  parameter int unsigned BYTES_PER_PIXEL  = DEF_BYTES_PER_PIXEL
) (
  input  logic [$clog2(PIXEL_WIDTH)-1:0]  x,
  input  logic [$clog2(PIXEL_HEIGHT)-1:0] y,
  input  logic [((num_colour_idx_bits(BYTES_PER_PIXEL) == 0) ? 1 :
                 num_colour_idx_bits(BYTES_PER_PIXEL))-1:0] colour_idx,
  output logic [num_address_a_bits(PIXEL_WIDTH, PIXEL_HEIGHT, PIXEL_HALFHEIGHT,
                                   BYTES_PER_PIXEL)-1:0] addr
);

  localparam int unsigned XW = $clog2(PIXEL_WIDTH);
  localparam int unsigned HB = $clog2(PIXEL_HALFHEIGHT);
  localparam int unsigned SB = num_subpanelselect_bits(PIXEL_HEIGHT, PIXEL_HALFHEIGHT);
  localparam int unsigned CB = num_colour_idx_bits(BYTES_PER_PIXEL);
  localparam int unsigned AW = num_address_a_bits(PIXEL_WIDTH, PIXEL_HEIGHT, PIXEL_HALFHEIGHT,
                                                  BYTES_PER_PIXEL);
  // Zero-width fields (single subpanel / one byte per pixel) collapse to a zero contribution
  localparam logic [AW-1:0] C_MASK = AW'((1 << CB) - 1);

  logic [AW-1:0] row_a, x_a, sub_a, c_a;

  assign row_a = AW'(y[HB-1:0]);
  assign x_a   = AW'(x);
  assign sub_a = AW'(y >> HB);
  assign c_a   = AW'(colour_idx) & C_MASK;
  assign addr  = (row_a << (XW + SB + CB)) | (x_a << (SB + CB)) | (sub_a << CB) | c_a;

endmodule

// File: rtl/fb_window_writer.sv
// Window write engine: streams or fills a rectangle of pixels into framebuffer port A.
module fb_window_writer
  import fb_window_writer_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH      = DEF_PIXEL_WIDTH,
  parameter int unsigned PIXEL_HEIGHT     = DEF_PIXEL_HEIGHT,
  parameter int unsigned PIXEL_HALFHEIGHT = DEF_PIXEL_HALFHEIGHT,
  parameter int unsigned BYTES_PER_PIXEL  = DEF_BYTES_PER_PIXEL
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [$clog2(PIXEL_WIDTH)-1:0]    cmd_x0,
  input  logic [$clog2(PIXEL_HEIGHT)-1:0]   cmd_y0,
  input  logic [$clog2(PIXEL_WIDTH):0]      cmd_w,
  input  logic [$clog2(PIXEL_HEIGHT):0]     cmd_h,
  input  logic                              cmd_fill,
  input  logic                              cmd_msb_first,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [7:0]                        in_data,
  input  logic                              abort,
  output logic                              wr_en,
  output logic [num_address_a_bits(PIXEL_WIDTH, PIXEL_HEIGHT, PIXEL_HALFHEIGHT,
                                   BYTES_PER_PIXEL)-1:0] wr_addr,
  output logic [7:0]                        wr_data,
  output logic                              done,
  output logic                              err
);

  localparam int unsigned XW  = $clog2(PIXEL_WIDTH);
  localparam int unsigned YW  = $clog2(PIXEL_HEIGHT);
  localparam int unsigned CB  = num_colour_idx_bits(BYTES_PER_PIXEL);
  localparam int unsigned CW  = (CB == 0) ? 1 : CB;
  localparam int unsigned BCW = $clog2(BYTES_PER_PIXEL) + 1;
  localparam int unsigned AW  = num_address_a_bits(PIXEL_WIDTH, PIXEL_HEIGHT, PIXEL_HALFHEIGHT,
                                                   BYTES_PER_PIXEL);

  state_e         state, state_nxt;
  window_cmd_t    win, win_nxt;
  logic [XW-1:0]  x, x_nxt;
  logic [YW-1:0]  y, y_nxt;
  logic [BCW-1:0] bcnt, bcnt_nxt;
  logic [7:0]     pixel [BYTES_PER_PIXEL];
  logic           load_en;
  logic           cmd_ready_nxt, in_ready_nxt, wr_en_nxt, done_nxt, err_nxt;
  logic [AW-1:0]  wr_addr_nxt, pack_addr;
  logic [7:0]     wr_data_nxt;

  logic [CW-1:0]  cidx;
  logic           last_byte, last_x, last_y, win_end, cmd_bad;
  logic [XW+1:0]  x_sum;
  logic [YW+1:0]  y_sum;

  assign cidx      = win.msb_first ? (CW'(BYTES_PER_PIXEL - 1) - CW'(bcnt)) : CW'(bcnt);
  assign last_byte = (bcnt == BCW'(BYTES_PER_PIXEL - 1));
  assign last_x    = (x == win.x_last);
  assign last_y    = (y == win.y_last);
  assign win_end   = last_byte && last_x && last_y;

  assign x_sum   = (XW+2)'(cmd_x0) + (XW+2)'(cmd_w);
  assign y_sum   = (YW+2)'(cmd_y0) + (YW+2)'(cmd_h);
  assign cmd_bad = (cmd_w == '0) || (cmd_h == '0) ||
                   (x_sum > (XW+2)'(PIXEL_WIDTH)) || (y_sum > (YW+2)'(PIXEL_HEIGHT));

  fb_addr_pack #(
    .PIXEL_WIDTH      (PIXEL_WIDTH),
    .PIXEL_HEIGHT     (PIXEL_HEIGHT),
    .PIXEL_HALFHEIGHT (PIXEL_HALFHEIGHT),
    .BYTES_PER_PIXEL  (BYTES_PER_PIXEL)
  ) u_addr_pack (
    .x          (x),
    .y          (y),
    .colour_idx (cidx),
    .addr       (pack_addr)
  );

  // Next state, traversal counters and registered-output values
  always_comb begin
    state_nxt   = state;
    win_nxt     = win;
    x_nxt       = x;
    y_nxt       = y;
    bcnt_nxt    = bcnt;
    load_en     = 1'b0;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr;
    wr_data_nxt = wr_data;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_bad) begin
            err_nxt = 1'b1;
          end else begin
            win_nxt.x0        = cmd_x0;
            win_nxt.x_last    = XW'((XW+1)'(cmd_x0) + cmd_w - (XW+1)'(1));
            win_nxt.y_last    = YW'((YW+1)'(cmd_y0) + cmd_h - (YW+1)'(1));
            win_nxt.msb_first = cmd_msb_first;
            x_nxt             = cmd_x0;
            y_nxt             = cmd_y0;
            bcnt_nxt          = '0;
            state_nxt         = cmd_fill ? ST_LOAD : ST_STREAM;
          end
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          load_en = 1'b1;
          if (last_byte) begin
            bcnt_nxt  = '0;
            state_nxt = ST_FILL;
          end else begin
            bcnt_nxt = bcnt + BCW'(1);
          end
        end
      end
      default: begin
        if ((state == ST_FILL) || in_valid) begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = pack_addr;
          wr_data_nxt = (state == ST_FILL) ? pixel[cidx] : in_data;
          if (last_byte) begin
            bcnt_nxt = '0;
            if (last_x) begin
              x_nxt = win.x0;
              if (!last_y) y_nxt = y + YW'(1);
            end else begin
              x_nxt = x + XW'(1);
            end
          end else begin
            bcnt_nxt = bcnt + BCW'(1);
          end
          if (win_end) begin
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
    endcase

    if (abort && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
      load_en   = 1'b0;
      wr_en_nxt = 1'b0;
      done_nxt  = 1'b0;
      x_nxt     = '0;
      y_nxt     = '0;
      bcnt_nxt  = '0;
    end

    cmd_ready_nxt = (state_nxt == ST_IDLE);
    in_ready_nxt  = (state_nxt == ST_LOAD) || (state_nxt == ST_STREAM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      win       <= '0;
      x         <= '0;
      y         <= '0;
      bcnt      <= '0;
      cmd_ready <= 1'b1;
      in_ready  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      win       <= win_nxt;
      x         <= x_nxt;
      y         <= y_nxt;
      bcnt      <= bcnt_nxt;
      cmd_ready <= cmd_ready_nxt;
      in_ready  <= in_ready_nxt;
      wr_en     <= wr_en_nxt;
      wr_addr   <= wr_addr_nxt;
      wr_data   <= wr_data_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

  // Fill pixel register, indexed by colour so fill writes reuse the traversal index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(BYTES_PER_PIXEL); i++) pixel[i] <= '0;
    end else if (load_en) begin
      pixel[cidx] <= in_data;
    end
  end

endmodule

// File: tb/tb_fb_window_writer.sv
// Scoreboard bench for fb_window_writer at 64x32, half 16, 2 bytes per pixel.
module tb_fb_window_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_fill, cmd_msb_first;
  logic [5:0]  cmd_x0;
  logic [4:0]  cmd_y0;
  logic [6:0]  cmd_w;
  logic [5:0]  cmd_h;
  logic        in_valid, in_ready, abort;
  logic [7:0]  in_data;
  logic        wr_en, done, err;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [19:0] sb [$];

  fb_window_writer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_fill(cmd_fill), .cmd_msb_first(cmd_msb_first),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .abort(abort),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] exp_addr(input int x, input int y, input int c);
    return 12'((((y % 16) * 64 + x) * 2 + y / 16) * 2 + c);
  endfunction

  // Write monitor: every write must match the head of the scoreboard; done must ride the last write
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write addr=%0d data=%02h", wr_addr, wr_data);
        end else begin
          logic [19:0] e;
          e = sb.pop_front();
          if ({wr_addr, wr_data} !== e) begin
            bad++;
            $display("FAIL write addr=%0d data=%02h expected addr=%0d data=%02h",
                     wr_addr, wr_data, e[19:8], e[7:0]);
          end
        end
      end
      if (done) begin
        done_cnt++;
        total++;
        if (!wr_en || sb.size() != 0) begin
          bad++;
          $display("FAIL done_align wr_en=%0b pending=%0d expected wr_en=1 pending=0",
                   wr_en, sb.size());
        end
      end
      if (err) err_cnt++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int x0, input int y0, input int w, input int h,
                          input bit fill, input bit msb);
    cmd_x0 = 6'(x0); cmd_y0 = 5'(y0); cmd_w = 7'(w); cmd_h = 6'(h);
    cmd_fill = fill; cmd_msb_first = msb; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  // Drive up to 'limit' bytes of a STREAM window, pushing each expected write first
  task automatic stream_window(input int x0, input int y0, input int w, input int h,
                               input bit msb, input int gap, input int limit);
    int n = 0;
    for (int yy = y0; yy < y0 + h; yy++)
      for (int xx = x0; xx < x0 + w; xx++)
        for (int k = 0; k < 2; k++) begin
          logic [7:0] d;
          if (n < limit) begin
            d = 8'($urandom_range(0, 255));
            sb.push_back({exp_addr(xx, yy, msb ? 1 - k : k), d});
            send_byte(d, gap);
            n++;
          end
        end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i = 0;
    while (i < budget && !(sb.size() == 0 && cmd_ready === 1'b1)) begin
      tick();
      i++;
    end
    total++;
    if (i >= budget) begin
      bad++;
      $display("FAIL %s_timeout pending=%0d cmd_ready=%0b expected pending=0 cmd_ready=1",
               name, sb.size(), cmd_ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) tick();
    total++;
    if ({cmd_ready, in_ready, wr_en, wr_addr, wr_data, done, err} !== {1'b1, 1'b0, 1'b0, 12'd0, 8'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs got rdy=%0b in_rdy=%0b wr_en=%0b addr=%0d data=%0h done=%0b err=%0b expected 1 0 0 0 0 0 0",
               cmd_ready, in_ready, wr_en, wr_addr, wr_data, done, err);
    end
    reset = 1'b0;
    tick();
    total++;
    if (cmd_ready !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset cmd_ready=%0b in_ready=%0b expected 1 0", cmd_ready, in_ready);
    end
  endtask

  task automatic test_single_pixel;
    int d0 = done_cnt;
    send_cmd(5, 20, 1, 1, 1'b0, 1'b1);
    total++;
    if (in_ready !== 1'b1 || cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL stream_entry in_ready=%0b cmd_ready=%0b expected 1 0", in_ready, cmd_ready);
    end
    sb.push_back({12'd1047, 8'hAA});
    sb.push_back({12'd1046, 8'hBB});
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    total++;
    if (in_ready !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("FAIL single_end in_ready=%0b done=%0b expected 0 1", in_ready, done);
    end
    wait_drain("single", 10);
    total++;
    if (done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL single_done_count got=%0d expected=1", done_cnt - d0);
    end
  endtask

  task automatic test_reject;
    int e0 = err_cnt;
    send_cmd(63, 0, 2, 1, 1'b0, 1'b0);
    total++;
    if (err !== 1'b1 || cmd_ready !== 1'b1 || wr_en !== 1'b0) begin
      bad++;
      $display("FAIL reject_x err=%0b cmd_ready=%0b wr_en=%0b expected 1 1 0", err, cmd_ready, wr_en);
    end
    tick();
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL reject_pulse_width err=%0b expected 0", err);
    end
    send_cmd(3, 3, 0, 2, 1'b0, 1'b0);
    total++;
    if (err !== 1'b1 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reject_w0 err=%0b cmd_ready=%0b expected 1 1", err, cmd_ready);
    end
    send_cmd(0, 31, 1, 2, 1'b1, 1'b0);
    send_cmd(0, 0, 1, 0, 1'b0, 1'b0);
    repeat (3) tick();
    total++;
    if (err_cnt - e0 !== 4 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reject_count got=%0d in_ready=%0b expected 4 0", err_cnt - e0, in_ready);
    end
  endtask

  task automatic test_row_wrap;
    int d0 = done_cnt;
    sb.push_back({12'd4088, 8'h11});
    sb.push_back({12'd4089, 8'h22});
    send_cmd(62, 15, 2, 2, 1'b0, 1'b0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    sb.push_back({exp_addr(63, 15, 0), 8'h33});
    sb.push_back({exp_addr(63, 15, 1), 8'h44});
    sb.push_back({12'd250, 8'h55});
    sb.push_back({12'd251, 8'h66});
    sb.push_back({exp_addr(63, 16, 0), 8'h77});
    sb.push_back({exp_addr(63, 16, 1), 8'h88});
    for (int i = 3; i <= 8; i++) send_byte(8'(i * 8'h11), 0);
    wait_drain("row_wrap", 10);
    total++;
    if (done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL row_wrap_done got=%0d expected=1", done_cnt - d0);
    end
  endtask

  task automatic test_fill;
    int d0 = done_cnt;
    int nw = 0;
    send_cmd(0, 0, 3, 1, 1'b1, 1'b0);
    send_byte(8'h12, 0);
    total++;
    if (in_ready !== 1'b1 || wr_en !== 1'b0) begin
      bad++;
      $display("FAIL load_mid in_ready=%0b wr_en=%0b expected 1 0", in_ready, wr_en);
    end
    for (int a = 0; a < 3; a++) begin
      sb.push_back({12'(a * 4), 8'h12});
      sb.push_back({12'(a * 4 + 1), 8'h34});
    end
    send_byte(8'h34, 0);
    for (int i = 0; i < 20 && done_cnt == d0; i++) begin
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL fill_in_ready in_ready=%0b expected 0", in_ready);
      end
      if (wr_en === 1'b1) nw++;
      tick();
    end
    wait_drain("fill", 10);
    total++;
    if (done_cnt - d0 !== 1 || nw !== 6) begin
      bad++;
      $display("FAIL fill_count done=%0d writes=%0d expected 1 6", done_cnt - d0, nw);
    end
  endtask

  task automatic test_abort;
    int d0 = done_cnt;
    send_cmd(10, 3, 2, 2, 1'b0, 1'b1);
    stream_window(10, 3, 2, 2, 1'b1, 0, 3);
    abort = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    total++;
    if (cmd_ready !== 1'b1 || in_ready !== 1'b0 || wr_en !== 1'b0) begin
      bad++;
      $display("FAIL abort_state cmd_ready=%0b in_ready=%0b wr_en=%0b expected 1 0 0",
               cmd_ready, in_ready, wr_en);
    end
    repeat (4) tick();
    total++;
    if (done_cnt !== d0 || sb.size() !== 0) begin
      bad++;
      $display("FAIL abort_tail done=%0d pending=%0d expected 0 0", done_cnt - d0, sb.size());
    end
  endtask

  task automatic test_async_reset;
    int d0 = done_cnt;
    send_cmd(30, 2, 2, 2, 1'b0, 1'b1);
    stream_window(30, 2, 2, 2, 1'b1, 0, 3);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    total++;
    if ({cmd_ready, in_ready, wr_en, wr_addr, wr_data, done} !== {1'b1, 1'b0, 1'b0, 12'd0, 8'd0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset rdy=%0b in_rdy=%0b wr_en=%0b addr=%0d data=%0h done=%0b expected 1 0 0 0 0 0",
               cmd_ready, in_ready, wr_en, wr_addr, wr_data, done);
    end
    tick();
    reset = 1'b0;
    tick();
    send_cmd(7, 9, 1, 1, 1'b0, 1'b1);
    stream_window(7, 9, 1, 1, 1'b1, 0, 2);
    wait_drain("post_reset", 10);
    total++;
    if (done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL post_reset_done got=%0d expected=1", done_cnt - d0);
    end
  endtask

  task automatic test_gaps;
    int d0 = done_cnt;
    int e0 = err_cnt;
    send_cmd(20, 8, 4, 4, 1'b0, 1'b1);
    send_cmd(0, 0, 0, 0, 1'b0, 1'b0);
    total++;
    if (cmd_ready !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL busy_cmd cmd_ready=%0b err=%0b expected 0 0", cmd_ready, err);
    end
    stream_window(20, 8, 4, 4, 1'b1, 2, 32);
    wait_drain("gaps", 20);
    total++;
    if (done_cnt - d0 !== 1 || err_cnt !== e0) begin
      bad++;
      $display("FAIL gaps_done done=%0d err=%0d expected 1 0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_back_to_back;
    int d0 = done_cnt;
    send_cmd(60, 31, 4, 1, 1'b0, 1'b0);
    stream_window(60, 31, 4, 1, 1'b0, 0, 8);
    send_cmd(0, 16, 1, 16, 1'b0, 1'b1);
    stream_window(0, 16, 1, 16, 1'b1, 0, 32);
    wait_drain("b2b", 10);
    total++;
    if (done_cnt - d0 !== 2) begin
      bad++;
      $display("FAIL b2b_done got=%0d expected=2", done_cnt - d0);
    end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0;
    cmd_fill = 1'b0; cmd_msb_first = 1'b0; in_valid = 1'b0; in_data = '0; abort = 1'b0;
    test_reset();
    test_single_pixel();
    test_reject();
    test_row_wrap();
    test_fill();
    test_abort();
    test_async_reset();
    test_gaps();
    test_back_to_back();
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
